// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents:
//   size_e  - access size encoding carried on req_size
//   state_e - control states of the load/store sequencer
//   is_misaligned() - alignment / legality check for a size and byte offset
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // The illegal size encoding is treated as misaligned so a single
    // check covers both reasons for rejecting on size/offset.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering for the load/store unit (little-endian).
// Ports:
//   old_word    in  32  word read from memory, base for a sub-word store
//   wdata       in  32  right-aligned store data
//   size        in  2   access size
//   byte_off    in  2   byte offset within the word (addr[1:0])
//   ld_unsigned in  1   1 = zero-extend load, 0 = sign-extend
//   ld_word     in  32  word the load result is extracted from
//   merged_word out 32  old_word with the addressed lane(s) replaced
//   ld_result   out 32  extracted, right-aligned, extended load value
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  byte_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] merged_word,
    output logic [31:0] ld_result
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;
    logic        ext_bit_s;

    // Store merge: overwrite only the addressed lane of the old word.
    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8]       = wdata[7:0];
            SZ_HALF: merged_word[{byte_off[1], 4'b0000} +: 16]  = wdata[15:0];
            SZ_WORD: merged_word = wdata;
            default: merged_word = old_word;
        endcase
    end

    // Load extract: right-align the lane, then fill upper bits with the
    // lane MSB (signed) or zero (unsigned).
    always_comb begin
        lane_byte_s = ld_word[{byte_off, 3'b000} +: 8];
        lane_half_s = ld_word[{byte_off[1], 4'b0000} +: 16];
        ext_bit_s   = 1'b0;
        ld_result   = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                ext_bit_s = ~ld_unsigned & lane_byte_s[7];
                ld_result = {{24{ext_bit_s}}, lane_byte_s};
            end
            SZ_HALF: begin
                ext_bit_s = ~ld_unsigned & lane_half_s[15];
                ld_result = {{16{ext_bit_s}}, lane_half_s};
            end
            SZ_WORD: ld_result = ld_word;
            default: ld_result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator in front of a word-addressed data
// memory (combinational read, synchronous word write, no byte enables).
// Sub-word stores are done as read-modify-write; sub-word loads are
// extracted and extended here. Illegal accesses fault without strobes.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in idle)
//   req_we, req_size, req_unsigned access type
//   req_addr, req_wdata            byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_fault  one-cycle completion
//   mem_addr, mem_write_data, mem_read_en, mem_write_en, mem_read_data
//                                  word-addressed memory interface
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DMEM_DEPTH_WORDS = 1024,
    localparam int WIDX            = $clog2(DMEM_DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [WIDX-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam logic [31:0] DEPTH_LIMIT = DMEM_DEPTH_WORDS[31:0];

    state_e             state_q, state_d;
    logic               we_q, we_d;
    size_e              size_q, size_d;
    logic               unsigned_q, unsigned_d;
    // Only the bits that select a word or lane are kept; the range
    // check is done on the full request address at accept time.
    logic [WIDX+1:0]    addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_word_q, rd_word_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_fault_q, resp_fault_d;

    logic               accept_s;
    logic               fault_s;
    logic [31:0]        merged_s;
    logic [31:0]        ld_result_s;

    assign accept_s = req_valid && req_ready;
    assign fault_s  = is_misaligned(size_e'(req_size), req_addr[1:0])
                    || ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);

    lsu_byte_lane u_lane (
        .old_word    (rd_word_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .byte_off    (addr_q[1:0]),
        .ld_unsigned (unsigned_q),
        .ld_word     (mem_read_data),
        .merged_word (merged_s),
        .ld_result   (ld_result_s)
    );

    // Next-state logic, request latch and response data staging.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_word_d    = rd_word_q;
        resp_rdata_d = 32'h0000_0000;
        resp_fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d       = req_we;
                    size_d     = size_e'(req_size);
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[WIDX+1:0];
                    wdata_d    = req_wdata;
                    if (fault_s) begin
                        state_d      = ST_RESP;
                        resp_fault_d = 1'b1;
                    end else if (req_we && (size_e'(req_size) == SZ_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_word_d = mem_read_data;
                if (we_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = ld_result_s;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            rd_word_q    <= 32'h0000_0000;
            resp_rdata_q <= 32'h0000_0000;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_word_q    <= rd_word_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Strobes and handshakes are state decodes gated by rst_n so that an
    // abandoned transaction cannot touch memory in the reset cycle.
    assign req_ready      = (state_q == ST_IDLE)  && rst_n;
    assign resp_valid     = (state_q == ST_RESP)  && rst_n;
    assign mem_read_en    = (state_q == ST_READ)  && rst_n;
    assign mem_write_en   = (state_q == ST_WRITE) && rst_n;
    assign resp_rdata     = resp_rdata_q;
    assign resp_fault     = resp_fault_q;
    assign mem_addr       = addr_q[WIDX+1:2];
    assign mem_write_data = merged_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a
// mid-transaction reset sequence, and randomized requests checked against
// an independent shift/mask model through a response scoreboard.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_read_en, mem_write_en;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_read_data(mem_read_data)
    );

    // Data memory model: combinational read, synchronous write; the bench
    // preloads through a side port while the unit is idle.
    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = 10'd0;
    logic [31:0] pre_data = 32'h0;
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_write_data;
        else if (pre_we)  mem[pre_idx] <= pre_data;
    end
    assign mem_read_data = mem[mem_addr];

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [9:0]  wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] wr_data;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[17];
    logic [31:0] shadow [0:15];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx[9:0]; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Drive one request, push its expectation, then watch strobes until
    // the response pops the scoreboard (bounded to 6 cycles).
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
        exp_t got;
        int   rd_seen, wr_seen, rd_cnt, wr_cnt;
        bit   done;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd_seen = 0; wr_seen = 0; rd_cnt = 0; wr_cnt = 0; done = 1'b0;
        for (int n = 1; n <= 6 && !done; n++) begin
            @(negedge clk);
            if (mem_read_en) begin
                rd_cnt++;
                if (rd_seen == 0) rd_seen = n;
            end
            if (mem_write_en) begin
                wr_cnt++;
                if (wr_seen == 0) wr_seen = n;
                chk("wr_addr", 32'(mem_addr), 32'(sb[0].wr_addr));
                chk("wr_data", mem_write_data, sb[0].wr_data);
            end
            if (resp_valid) begin
                got = sb.pop_front();
                done = 1'b1;
                chk("latency", n, got.lat);
                chk("rdata", resp_rdata, got.rdata);
                chk("fault", 32'(resp_fault), 32'(got.fault));
                chk("rd_cycle", rd_seen, got.rd_cyc);
                chk("wr_cycle", wr_seen, got.wr_cyc);
                chk("rd_count", rd_cnt, (got.rd_cyc != 0) ? 1 : 0);
                chk("wr_count", wr_cnt, (got.wr_cyc != 0) ? 1 : 0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no resp_valid expected within 6 cycles addr=0x%08h", addr);
            if (sb.size() > 0) got = sb.pop_front();
        end
    endtask

    // Independent reference: shift/mask arithmetic over a shadow memory.
    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w, mask, v;
        int          sh;
        e.fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                  (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
        e.wr_addr = a[11:2];
        e.rdata = 32'h0; e.rd_cyc = 0; e.wr_cyc = 0; e.wr_data = 32'h0; e.lat = 1;
        w    = shadow[a[5:2]];
        sh   = 8 * int'(a[1:0]);
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!e.fault) begin
            if (we) begin
                e.wr_data = (w & ~(mask << sh)) | ((wd & mask) << sh);
                if (sz == 2'b10) begin e.lat = 2; e.wr_cyc = 1; end
                else begin e.lat = 3; e.rd_cyc = 1; e.wr_cyc = 2; end
            end else begin
                v = (w >> sh) & mask;
                if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
                e.rdata = v; e.lat = 2; e.rd_cyc = 1;
            end
        end
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] a, wd;

        //              we    sz     uns   addr          wdata         rdata         flt  lat rd wr wr_data
        vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0,        32'hFFFF_FFAA, 1'b0, 2, 1, 0, 32'h0};
        vt[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0,        32'h0000_8899, 1'b0, 2, 1, 0, 32'h0};
        vt[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_1234, 32'h0,        1'b0, 3, 1, 2, 32'h1234_AABB};
        vt[3]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEAD_BEEF};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vt[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0004, 32'h0,        32'hFFFF_AABB, 1'b0, 2, 1, 0, 32'h0};
        vt[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0007, 32'h0,        32'h0000_0088, 1'b0, 2, 1, 0, 32'h0};
        vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0,        32'hFFFF_FFBB, 1'b0, 2, 1, 0, 32'h0};
        vt[9]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0,        32'h8899_AABB, 1'b0, 2, 1, 0, 32'h0};
        vt[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0007, 32'h0000_0055, 32'h0,        1'b0, 3, 1, 2, 32'h5599_AABB};
        vt[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_5678, 32'h0,        1'b0, 3, 1, 2, 32'h8899_78BB};
        vt[12] = '{1'b0, 2'b11, 1'b0, 32'h0000_0004, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vt[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,        32'h0BAD_F00D, 1'b0, 2, 1, 0, 32'h0};
        vt[15] = '{1'b1, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h1111_2222, 32'h0,        1'b1, 1, 0, 0, 32'h0};
        vt[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0007, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", req_ready, 32'd0);
        chk("rd_en_in_reset", mem_read_en, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", req_ready, 32'd1);
        chk("reset_resp_valid", resp_valid, 32'd0);
        chk("reset_resp_fault", resp_fault, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_rd_en", mem_read_en, 32'd0);
        chk("reset_wr_en", mem_write_en, 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);

        preload(1023, 32'h0BAD_F00D);
        for (int i = 0; i < 17; i++) begin
            preload(1, 32'h8899_AABB);
            e.rdata = vt[i].rdata; e.fault = vt[i].fault; e.lat = vt[i].lat;
            e.rd_cyc = vt[i].rd_cyc; e.wr_cyc = vt[i].wr_cyc;
            e.wr_addr = vt[i].addr[11:2]; e.wr_data = vt[i].wr_data;
            run_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, e);
        end

        // Byte store abandoned by reset in the read cycle.
        preload(1, 32'h8899_AABB);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0004; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_wr_en", mem_write_en, 32'd0);
        chk("rst_mid_resp", resp_valid, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) chk("rst_mid_ready", req_ready, 32'd1);
            chk("rst_after_wr_en", mem_write_en, 32'd0);
            chk("rst_after_resp", resp_valid, 32'd0);
        end
        chk("rst_mem_word1", mem[1], 32'h8899_AABB);

        // Randomized traffic over words 0..15 plus out-of-range addresses.
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            preload(i, shadow[i]);
        end
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h0000_1000 + 32'($urandom_range(0, 255));
            else                           a = 32'($urandom_range(0, 63));
            e = model(we, sz, uns, a, wd);
            run_req(we, sz, uns, a, wd, e);
            if (we && !e.fault) shadow[a[5:2]] = e.wr_data;
        end
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], shadow[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-addressed load/store initiator between the CPU core's memory stage and the word-addressed data memory. The memory has combinational read, synchronous word write, and no byte enables. Converts core requests (byte/half/word, signed/unsigned) into word reads and writes. Performs read-modify-write for sub-word stores, extracts and extends sub-word loads, and faults misaligned or out-of-range accesses without touching memory.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; only 32 supported.
- DMEM_DEPTH_WORDS, 1024, memory depth in words. Word index width is WIDX = $clog2(DMEM_DEPTH_WORDS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and faults.
- resp_fault  out  1  access rejected, valid with resp_valid.
- mem_addr  out  WIDX  word index.
- mem_write_data  out  32  merged store word.
- mem_read_en  out  1  read strobe.
- mem_write_en  out  1  write strobe.
- mem_read_data  in  32  combinational read data for mem_addr.

## Operation
- States: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- req_ready = 1 only in IDLE with rst_n high. A request is accepted when req_valid && req_ready. On accept, the unit latches we, size, unsigned, addr and wdata.
- Fault check at accept; any one of these faults the request:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DMEM_DEPTH_WORDS.
- Fault path: IDLE→RESP with resp_fault=1. No mem strobes are asserted.
- Load: IDLE→READ→RESP. In READ, mem_read_en=1 and mem_read_data is captured into a word register.
- Word store: IDLE→WRITE→RESP. No read is issued.
- Byte/half store: IDLE→READ→WRITE→RESP. The captured word is merged with wdata and mem_write_data carries the merge result.
- Lane selection is little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Load extraction right-aligns the selected lane. Sign extension takes the lane MSB; zero extension fills with 0.
- mem_addr = latched addr[WIDX+1:2] in every state, and holds when idle.
- mem_read_en is high only in READ; mem_write_en is high only in WRITE. Both are gated by rst_n (forced 0 when rst_n=0).
- RESP lasts exactly one cycle, then returns to IDLE. There is no response backpressure.
- Reset values: state IDLE; all registers 0; resp_valid, resp_fault, resp_rdata, mem_read_en and mem_write_en all 0; mem_addr 0.

## Timing
- Accept cycle is k. Response latencies (resp_valid high in cycle):
  - fault: k+1;
  - word store: k+2, with write in cycle k+1;
  - load: k+2, with read in cycle k+1;
  - sub-word store: k+3, with read in k+1 and write in k+2.
- Next accept is possible in the cycle after RESP. Throughput is one request per 2–4 cycles.
- Reset asserted mid-operation: the transaction is abandoned, no strobe is asserted from that cycle on, and no response is produced. After the reset edge with rst_n high, req_ready=1.
- Simultaneous events: req_valid during non-IDLE states is ignored and must be held by the core.

## Structure
- Package lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL);
  - state enum (ST_IDLE, ST_READ, ST_WRITE, ST_RESP).
- Sub-module lsu_byte_lane: purely combinational. Store merge takes (old word, wdata, size, addr[1:0]) and returns the new word. Load extract takes (word, size, addr[1:0], unsigned) and returns the result.
- Top level contains the FSM, request latch and read capture register.

## Test plan
Preload word index 1 = 0x8899AABB before each scenario.
- Signed byte load at addr 0x5 → mem_read_en in k+1, resp_valid in k+2, resp_rdata=0xFFFFFFAA, resp_fault=0.
- Unsigned half load at addr 0x6 → resp_rdata=0x00008899 in k+2.
- Half store 0x00001234 at addr 0x6 → read in k+1, mem_write_en in k+2 with mem_addr=1 and mem_write_data=0x1234AABB, resp_valid in k+3.
- Word store 0xDEADBEEF at addr 0x8 → mem_write_en in k+1 with mem_addr=2, mem_read_en never high, resp_valid in k+2.
- Word load at addr 0x2, then byte load at addr 0x1000 → each gives resp_fault=1 in k+1, with no mem strobe in either transaction.
- Byte store at addr 0x4 with rst_n driven low in cycle k+1 → mem_write_en stays 0 throughout, word 1 stays 0x8899AABB, no resp_valid, and req_ready=1 once rst_n returns high.
